// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, and fetches over a
// req/gnt/rvalid memory port with at most one request outstanding.
module if_fetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INSN = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_pc_out,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instruction
);

    typedef enum logic [1:0] {
        StReq  = 2'd0,
        StWait = 2'd1,
        StFull = 2'd2
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] insn_buf_q;
    logic            drop_q;
    logic            id_valid_q;
    logic [XLEN-1:0] id_pc_q;
    logic [XLEN-1:0] id_insn_q;

    logic            from_mem;
    logic            from_buf;
    logic            deliver;
    logic            id_load;
    logic [XLEN-1:0] deliver_insn;
    logic [XLEN-1:0] pc_inc;

    // Request is decoded from registered state only; reset gates it off immediately.
    assign imem_req       = ~rst & (state_q == StReq);
    assign imem_addr      = pc_q;
    assign if_pc_out      = pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_instruction = id_insn_q;

    always_comb begin
        from_mem     = (state_q == StWait) && imem_rvalid && !drop_q;
        from_buf     = (state_q == StFull);
        deliver      = !flush && !stall && (from_mem || from_buf);
        deliver_insn = from_buf ? insn_buf_q : imem_rdata;
        // IF/ID is rewritten every cycle unless decode is stalled; flush always bubbles it.
        id_load      = flush || !stall;
        pc_inc       = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            insn_buf_q <= '0;
            drop_q     <= 1'b0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_insn_q  <= NOP_INSN;
        end else begin
            if (id_load) begin
                id_valid_q <= deliver;
                id_pc_q    <= pc_q;
                id_insn_q  <= deliver ? deliver_insn : NOP_INSN;
            end

            if (flush) begin
                pc_q <= redirect_pc;
            end else if (deliver) begin
                pc_q <= pc_inc;
            end

            if (flush) begin
                case (state_q)
                    StReq: begin
                        // A grant in the flush cycle fetches a wrong-path address.
                        if (imem_gnt) begin
                            state_q <= StWait;
                            drop_q  <= 1'b1;
                        end
                    end
                    StWait: begin
                        if (imem_rvalid) begin
                            state_q <= StReq;
                            drop_q  <= 1'b0;
                        end else begin
                            drop_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StReq;
                    end
                endcase
            end else begin
                case (state_q)
                    StReq: begin
                        if (imem_gnt) begin
                            state_q <= StWait;
                        end
                    end
                    StWait: begin
                        if (imem_rvalid) begin
                            if (drop_q) begin
                                drop_q  <= 1'b0;
                                state_q <= StReq;
                            end else if (!stall) begin
                                state_q <= StReq;
                            end else begin
                                insn_buf_q <= imem_rdata;
                                state_q    <= StFull;
                            end
                        end
                    end
                    StFull: begin
                        if (!stall) begin
                            state_q <= StReq;
                        end
                    end
                    default: begin
                        state_q <= StReq;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic against an
// in-order instruction-stream model with a latency-randomised memory.
module tb_if_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, if_pc_out;
    logic        id_valid;
    logic [31:0] id_pc, id_instruction;

    logic        w_imem_req, w_rv, w_id_valid;
    logic [31:0] w_imem_addr, w_rdata, w_if_pc_out, w_id_pc, w_id_instruction;
    logic [31:0] w_a0, w_a1;
    int          w_n = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSN(NOP)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_pc_out(if_pc_out),
        .id_valid(id_valid), .id_pc(id_pc), .id_instruction(id_instruction)
    );

    // Second instance exercises PC wrap-around against an always-granting zero-wait memory.
    if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSN(NOP)) u_dut_wrap (
        .clk(clk), .rst(rst), .stall(1'b0), .flush(1'b0), .redirect_pc(32'h0),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_gnt(1'b1),
        .imem_rvalid(w_rv), .imem_rdata(w_rdata), .if_pc_out(w_if_pc_out),
        .id_valid(w_id_valid), .id_pc(w_id_pc), .id_instruction(w_id_instruction)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            w_rv    <= 1'b0;
            w_rdata <= 32'h0;
        end else begin
            w_rv    <= w_imem_req;
            w_rdata <= w_imem_addr ^ KEY;
        end
    end

    always @(posedge clk) begin
        if (w_imem_req && w_n < 2) begin
            if (w_n == 0) w_a0 <= w_imem_addr;
            else          w_a1 <= w_imem_addr;
            w_n <= w_n + 1;
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          pend     = 1'b0;
    int          cnt      = 0;
    logic [31:0] paddr    = 32'h0;
    logic [31:0] exp_pc   = 32'h0;
    int          delivered = 0;
    logic [31:0] gaddr_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, let the edge happen, advance memory and model, check.
    task automatic step(input bit gnt, input bit stl, input bit fl, input logic [31:0] rpc,
                        input int lat);
        logic        pre_req, pre_v;
        logic [31:0] pre_addr, pre_pc, pre_insn;
        bit          rv;
        rv          = pend && (cnt == 0);
        imem_gnt    = gnt;
        stall       = stl;
        flush       = fl;
        redirect_pc = rpc;
        imem_rvalid = rv;
        imem_rdata  = rv ? (paddr ^ KEY) : $urandom;
        pre_req     = imem_req;
        pre_addr    = imem_addr;
        pre_v       = id_valid;
        pre_pc      = id_pc;
        pre_insn    = id_instruction;
        if (gnt && pre_req) begin
            check("one_outstanding", {31'b0, pend && !rv}, 32'h0);
            gaddr_q.push_back(pre_addr);
        end
        @(posedge clk);
        #1;
        if (rv) pend = 1'b0;
        if (gnt && pre_req) begin
            pend  = 1'b1;
            paddr = pre_addr;
            cnt   = lat - 1;
        end else if (pend && cnt > 0) begin
            cnt--;
        end
        if (fl) begin
            check("flush_bubble_valid", {31'b0, id_valid}, 32'h0);
            check("flush_bubble_insn", id_instruction, NOP);
            exp_pc = rpc;
        end else if (stl) begin
            check("stall_hold_valid", {31'b0, id_valid}, {31'b0, pre_v});
            check("stall_hold_pc", id_pc, pre_pc);
            check("stall_hold_insn", id_instruction, pre_insn);
        end else if (id_valid) begin
            check("stream_pc", id_pc, exp_pc);
            check("stream_insn", id_instruction, exp_pc ^ KEY);
            exp_pc = exp_pc + 32'd4;
            delivered++;
        end else begin
            check("bubble_insn", id_instruction, NOP);
        end
        check("if_pc", if_pc_out, exp_pc);
        if (imem_req) check("imem_addr", imem_addr, exp_pc);
    endtask

    initial begin
        logic [31:0] s_pc, s_insn;
        logic        s_v;
        bit          seen;
        int          d0;

        rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid", {31'b0, id_valid}, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_insn", id_instruction, NOP);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_pc", if_pc_out, 32'h0);
        check("rst_wrap_pc", w_if_pc_out, 32'hFFFF_FFFC);
        rst = 1'b0;
        #1;
        check("first_req", {31'b0, imem_req}, 32'h1);
        check("first_addr", imem_addr, 32'h0);

        // Zero-wait memory: one instruction every two cycles.
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1);
            if (i == 2) begin
                check("zw_valid0", {31'b0, id_valid}, 32'h1);
                check("zw_pc0", id_pc, 32'h0);
                check("wrap_valid", {31'b0, w_id_valid}, 32'h1);
                check("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
                check("wrap_id_insn", w_id_instruction, 32'hFFFF_FFFC ^ KEY);
                check("wrap_if_pc", w_if_pc_out, 32'h0);
            end
            if (i == 3) check("zw_bubble", {31'b0, id_valid}, 32'h0);
            if (i == 4) check("zw_pc4", id_pc, 32'h4);
            if (i == 6) check("zw_pc8", id_pc, 32'h8);
        end
        check("zw_ngrants", gaddr_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < gaddr_q.size(); i++)
            check("zw_addr_seq", gaddr_q[i], 32'(i * 4));
        check("wrap_addr0", w_a0, 32'hFFFF_FFFC);
        check("wrap_addr1", w_a1, 32'h0);

        // Response lands under a 3-cycle stall.
        s_v = id_valid; s_pc = id_pc; s_insn = id_instruction;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1);
            check("full_hold_pc", id_pc, s_pc);
            check("full_hold_insn", id_instruction, s_insn);
            check("full_hold_valid", {31'b0, id_valid}, {31'b0, s_v});
            check("full_no_req", {31'b0, imem_req}, 32'h0);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        check("unstall_valid", {31'b0, id_valid}, 32'h1);
        check("unstall_pc", id_pc, 32'hC);
        check("unstall_insn", id_instruction, 32'hC ^ KEY);
        check("unstall_next_addr", imem_addr, 32'h10);

        // Flush while a slow response is in flight.
        step(1'b1, 1'b0, 1'b0, 32'h0, 3);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1);
        check("wflush_no_req", {31'b0, imem_req}, 32'h0);
        for (int i = 0; i < 10 && !imem_req; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        check("wflush_req", {31'b0, imem_req}, 32'h1);
        check("wflush_addr", imem_addr, 32'h40);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        check("wflush_first_valid", {31'b0, id_valid}, 32'h1);
        check("wflush_first_pc", id_pc, 32'h40);

        // Flush coinciding with a grant in REQ.
        step(1'b1, 1'b0, 1'b1, 32'h80, 2);
        check("gflush_wait", {31'b0, imem_req}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (imem_req && !seen) begin
                check("gflush_addr", imem_addr, 32'h80);
                seen = 1'b1;
            end
            step(1'b1, 1'b0, 1'b0, 32'h0, 1);
            if (id_valid) break;
        end
        check("gflush_valid", {31'b0, id_valid}, 32'h1);
        check("gflush_pc", id_pc, 32'h80);

        // Flush and stall together while the buffer is full.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1);
        check("ff_full", {31'b0, imem_req}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h100, 1);
        check("ff_valid", {31'b0, id_valid}, 32'h0);
        check("ff_req", {31'b0, imem_req}, 32'h1);
        check("ff_addr", imem_addr, 32'h100);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        check("ff_next_pc", id_pc, 32'h100);
        check("ff_next_valid", {31'b0, id_valid}, 32'h1);

        // Random traffic.
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, $urandom_range(0, 24) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(1, 3));
        end
        check("rand_progress", {31'b0, (delivered - d0) > 100}, 32'h1);

        // Reset asserted in the middle of a transaction.
        for (int i = 0; i < 12 && !imem_req; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 3);
        check("mid_wait", {31'b0, imem_req}, 32'h0);
        rst = 1'b1;
        #1;
        check("mrst_valid", {31'b0, id_valid}, 32'h0);
        check("mrst_req", {31'b0, imem_req}, 32'h0);
        check("mrst_insn", id_instruction, NOP);
        check("mrst_pc", if_pc_out, 32'h0);
        check("mrst_wrap_req", {31'b0, w_imem_req}, 32'h0);
        pend = 1'b0; exp_pc = 32'h0; imem_rvalid = 1'b0; imem_gnt = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("mrst_req_after", {31'b0, imem_req}, 32'h1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1);
        check("mrst_resume_pc", id_pc, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
